// File: rtl/uart_rx_if.sv
//------------------------------------------------------------------------------
// uart_rx_if : serial line and received-byte signals of the UART receiver.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx : 8-bit LSB-first UART receiver with framing-error detection.
//           Optional parity bit enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ODD = 0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  uart_rx_if.slave  bus
);

  localparam logic [15:0] c_BAUD_LAST = 16'(CLOCK_FREQ / BAUD_RATE - 1);
  localparam logic [15:0] c_HALF_LAST = 16'(CLOCK_FREQ / BAUD_RATE / 2 - 1);
  localparam logic        c_PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_parity_err;
  logic        r_busy;
  logic        w_rx_s;

`ifdef UART_RX_PARITY_EN
  logic        r_par_bit;
`else
  logic        w_unused_par_odd;
  assign w_unused_par_odd = c_PAR_ODD;
`endif

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject short glitches.
        S_START: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt <= 16'd0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (r_cnt == c_BAUD_LAST) begin
            r_cnt     <= 16'd0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == c_BAUD_LAST) begin
            r_cnt     <= 16'd0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif

        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        S_STOP: begin
          if (r_cnt == c_BAUD_LAST) begin
            r_cnt <= 16'd0;
            if (w_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bit ^ (^r_shift) ^ c_PAR_ODD;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8 data bits, LSB first, 1 stop bit; receive-side counterpart of the uart_tx transmitter (idle-high line, same CLOCK_FREQ/BAUD_RATE timing).
- Synchronises the asynchronous rx pin, validates the start bit at mid-bit and samples each following bit at its centre.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board UART RX pin and the byte-consumer logic (command parser / FIFO).

Parameters:
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_RX_PARITY_EN is defined.
- Derived: BAUD_TICK = CLOCK_FREQ/BAUD_RATE (clocks per bit); HALF_TICK = BAUD_TICK/2. BAUD_TICK must be at least 4 and at most 65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  8  last correctly framed byte; holds its value until the next good byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new in the same cycle.
- frame_err  output  1  one-cycle pulse; the stop bit was sampled low.
- parity_err  output  1  one-cycle pulse coincident with rx_valid when parity mismatches; tied 0 without the macro.
- busy  output  1  high while a frame is in progress, i.e. state != IDLE.

Behaviour:
- Reset: rst_n low acts immediately (async), including mid-frame. Effects: state=IDLE, both sync flops=1, counters=0, shift register=0, rx_data=0x00, rx_valid=0, frame_err=0, parity_err=0, busy=0.
- Synchroniser: two flops on rx give rx_s. All logic uses rx_s only, so it lags the pin by 2 cycles.
- Counters: 16-bit baud counter and 3-bit bit index.
- All outputs are registered.
- IDLE: on rx_s==0, go to START, clear the counter, set busy=1.
- START: count to HALF_TICK-1, then check rx_s.
  - rx_s==0: go to DATA, clear counter, bit_idx=0.
  - rx_s==1: glitch; return to IDLE with no pulses and busy=0.
- DATA: count to BAUD_TICK-1, then sample rx_s.
  - Sample shifts into shift[7] while the register shifts right, giving LSB-first assembly.
  - Counter clears; bit_idx increments.
  - After bit_idx==7: go to STOP, or to PARITY when the macro is defined.
- STOP: count to BAUD_TICK-1, then sample rx_s.
  - rx_s==1: rx_data<=shift, rx_valid=1 for one cycle, go to IDLE, busy=0.
  - rx_s==0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
- BREAK: busy stays 1; stay until rx_s==1, then go to IDLE.
- Return to IDLE happens at mid-stop-bit, so a start edge immediately after the stop bit (back-to-back frames) is caught.
- Latency: rx_valid asserts 3 + HALF_TICK + 9*BAUD_TICK cycles (±1) after the rx pin falling edge of the start bit (8N1).
- rx_valid, frame_err and parity_err are never high for more than one consecutive cycle. rx_valid and frame_err are mutually exclusive.
- Edges during DATA or STOP are ignored; timing is set solely by the counter from the start edge.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA, one BAUD_TICK long, sampling at its end.
  - Expected bit = ^shift XOR PARITY_ODD.
  - At STOP success, parity_err = (sampled != expected), pulsed together with rx_valid. Data is still delivered.
  - On a framing error, parity_err stays 0.
  - Latency grows by BAUD_TICK.
- Undefined: no PARITY state, parity_err constant 0, PARITY_ODD ignored.

Test Plan:
(All scenarios use CLOCK_FREQ=160, BAUD_RATE=10, giving BAUD_TICK=16 and HALF_TICK=8.)
1. Drive 8N1 frame 0x55 after idle -> exactly one rx_valid pulse, rx_data=0x55, frame_err=0, busy falls with the pulse; rx_valid at 3+8+144 cycles (±1) from start edge.
2. Back-to-back frames 0xA3 then 0x0F, second start bit directly after first stop bit -> two rx_valid pulses, rx_data=0xA3 then 0x0F.
3. rx low for 3 cycles then high (glitch) -> no rx_valid/frame_err, busy high then 0 within 12 cycles, state IDLE.
4. Frame 0x3C with stop bit 0 and line held low 40 more cycles, after a good 0x0F -> frame_err one pulse, no rx_valid, rx_data stays 0x0F, busy stays 1 until rx returns high then 0.
5. rst_n low during data bit 3 of a frame -> all outputs at reset values immediately; after release, frame 0x81 received correctly with rx_data=0x81.
6. With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> rx_valid, parity_err=0; 0x07 with parity bit 0 -> rx_valid and parity_err pulse in the same cycle, rx_data=0x07.
